acm_operand_feeder: RTL and testbench
=====================================

Name: acm_operand_feeder

Overview:
Upstream stage of the 6-bit accumulator. Captures operands entered on switches with a push button into a small FIFO, then releases them one per clock onto the accumulator's x input while run is high. When not releasing, it drives x = 0, so the accumulator holds its sum. Provides fill status and a sticky drop flag for LEDs.

Parameters:
N, 6, operand width; matches the accumulator's data width.
DEPTH, 4, FIFO entries; must be a power of two, at least 2.
CW, $clog2(DEPTH)+1 (derived localparam, not overridable), width of count.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high; clears all state.
din  input  N  operand from switches; sampled on the write edge.
push  input  1  raw button level, asynchronous to clock.
run  input  1  level; enables release of operands to x.
x  output  N  registered operand to accumulator; 0 when idle.
count  output  CW  entries currently stored, 0..DEPTH.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
drop  output  1  sticky: a push was lost because the FIFO was full.

Behaviour:
- Reset, asynchronous, active-high; applies immediately and overrides everything. Reset values: x=0, count=0, empty=1, full=0, drop=0. The read pointer, write pointer, sync flops and edge-detect flop all go to 0. FIFO memory contents are don't-care.
- Push synchronizer: push passes through two flops (p1, p2), then a third flop (p3). push_evt = p2 & ~p3, so there is one event per rising level of the button.
  - A push rise sampled at edge k gives push_evt high during the cycle after edge k+1. The write happens at edge k+2, and din is sampled at that edge.
  - Holding push high gives exactly one event. No debounce is done here: bounces produce multiple events.
- Pop: pop = run & ~empty, evaluated on the state before the edge.
  - On an edge with pop=1: x <= mem[rd], and rd advances.
  - On any edge with pop=0: x <= 0.
  - x is a pure register output, so the accumulator sees each operand for exactly one cycle.
- Write: wr = push_evt & (~full | pop).
  - On an edge with wr=1: mem[wr_ptr] <= din, and wr_ptr advances.
  - Push while full with pop also active: accepted, because the slot freed that edge is reused.
  - Push while full with pop=0: operand discarded, drop <= 1. drop stays set until reset.
- count update: +1 on wr & ~pop, -1 on pop & ~wr, unchanged when both or neither occur. full and empty are combinational from count.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push into an empty FIFO while run=1: the entry is not popped on the write edge (empty was true before it). It appears on x at the next edge, giving 1 cycle latency from write to x.
- Ordering is strict FIFO. Widths are fixed: no arithmetic on data, operands pass through unchanged.
- run falling: x returns to 0 on the next edge. Remaining entries are retained.
- Reset mid-operation: all stored operands are lost and x=0 immediately.

Test Plan:
1. Reset with push=0 and run=0 -> x=0, count=0, empty=1, full=0, drop=0. Assert reset asynchronously mid-cycle and check the outputs clear before the next edge.
2. Run=0; push din=5, 3, 9 as separate single rises -> count=3. Then run=1 -> x shows 5, 3, 9 on three consecutive cycles, then 0. With the accumulator downstream, s goes 5, 8, 17 and then holds 17.
3. Run=0; five pushes of 1, 2, 3, 4, 5 -> full=1 after the fourth, count=4, drop=1 after the fifth. Then run=1 -> x shows 1, 2, 3, 4 and 5 never appears. drop remains 1 until reset.
4. Full FIFO holding 10, 11, 12, 13 with run=1, and a push of din=20 whose event lands on the first pop edge -> write accepted, drop=0, count stays 4 on that edge. x shows 10, 11, 12, 13, 20.
5. Push held high for 20 cycles with din=7 -> exactly one entry, count=1. A glitch pulse of 2 cycles -> one entry.
6. Pointer wrap: 10 cycles of alternating single push/pop with run=1, din = 1..10 -> x sequence is 1..10 in order, count never exceeds 1, and the pointers wrap twice with no data loss.

Source files
------------

// File: rtl/acm_operand_feeder.sv
// Operand feeder for the 6-bit accumulator: button-captured operands are queued in a small FIFO
// and released one per clock onto x while run is high; x is zero otherwise.
module acm_operand_feeder #(
   parameter int unsigned N     = 6,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [N-1:0]             din,
   input  logic                     push,
   input  logic                     run,
   output logic [N-1:0]             x,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     drop
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [CW-1:0] FullCount = CW'(DEPTH);

   logic          p1_q, p2_q, p3_q;
   logic [AW-1:0] rd_q, rd_d;
   logic [AW-1:0] wr_q, wr_d;
   logic [CW-1:0] count_q, count_d;
   logic [N-1:0]  x_q, x_d;
   logic          drop_q, drop_d;
   logic [N-1:0]  mem_q [DEPTH];

   logic push_evt;
   logic pop;
   logic wr;

   assign full  = (count_q == FullCount);
   assign empty = (count_q == '0);
   assign count = count_q;
   assign x     = x_q;
   assign drop  = drop_q;

   always_comb begin
      push_evt = p2_q & ~p3_q;
      pop      = run & ~empty;
      // A full FIFO still accepts a write when the same edge frees a slot.
      wr       = push_evt & (~full | pop);
      rd_d     = rd_q;
      wr_d     = wr_q;
      count_d  = count_q;
      x_d      = '0;
      drop_d   = drop_q | (push_evt & ~wr);
      if (pop) begin
         x_d  = mem_q[rd_q];
         rd_d = rd_q + 1'b1;
      end
      if (wr) begin
         wr_d = wr_q + 1'b1;
      end
      if (wr && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !wr) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         p1_q    <= 1'b0;
         p2_q    <= 1'b0;
         p3_q    <= 1'b0;
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
         x_q     <= '0;
         drop_q  <= 1'b0;
      end else begin
         p1_q    <= push;
         p2_q    <= p1_q;
         p3_q    <= p2_q;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
         x_q     <= x_d;
         drop_q  <= drop_d;
      end
   end

   // Storage needs no reset; stale contents are never read past count.
   always_ff @(posedge clock) begin
      if (wr) begin
         mem_q[wr_q] <= din;
      end
   end

endmodule

// File: tb/tb_acm_operand_feeder.sv
// Directed self-checking bench for acm_operand_feeder.
module tb_acm_operand_feeder;

   logic       clock;
   logic       reset;
   logic [5:0] din;
   logic       push;
   logic       run;
   logic [5:0] x;
   logic [2:0] count;
   logic       full;
   logic       empty;
   logic       drop;

   int checks = 0;
   int errors = 0;
   int max_count;

   acm_operand_feeder #(.N(6), .DEPTH(4)) dut (
      .clock (clock),
      .reset (reset),
      .din   (din),
      .push  (push),
      .run   (run),
      .x     (x),
      .count (count),
      .full  (full),
      .empty (empty),
      .drop  (drop)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Single rise: sampled at the first edge, written at the third edge.
   task automatic push_op(input logic [5:0] d);
      din  = d;
      push = 1'b1;
      tick();
      push = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      reset = 1'b1;
      push  = 1'b0;
      run   = 1'b0;
      din   = '0;
      tick();
      chk("rst_x", x, 0);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_drop", drop, 0);
      reset = 1'b0;
      tick();
      chk("idle_x", x, 0);

      // Three operands queued, then released in order
      push_op(6'd5);
      push_op(6'd3);
      push_op(6'd9);
      chk("t2_count", count, 3);
      chk("t2_x_idle", x, 0);
      run = 1'b1;
      tick(); chk("t2_x0", x, 5);
      tick(); chk("t2_x1", x, 3);
      tick(); chk("t2_x2", x, 9);
      tick(); chk("t2_x3", x, 0);
      chk("t2_empty", empty, 1);
      run = 1'b0;

      // Overflow sets drop; the fifth operand is lost
      push_op(6'd1);
      push_op(6'd2);
      push_op(6'd3);
      chk("t3_full3", full, 0);
      push_op(6'd4);
      chk("t3_full4", full, 1);
      chk("t3_count4", count, 4);
      chk("t3_drop4", drop, 0);
      push_op(6'd5);
      chk("t3_drop5", drop, 1);
      chk("t3_count5", count, 4);
      run = 1'b1;
      tick(); chk("t3_x0", x, 1);
      tick(); chk("t3_x1", x, 2);
      tick(); chk("t3_x2", x, 3);
      tick(); chk("t3_x3", x, 4);
      tick(); chk("t3_x4", x, 0);
      chk("t3_drop_sticky", drop, 1);
      run = 1'b0;

      // Asynchronous reset mid-cycle clears everything before the next edge
      push_op(6'd6);
      push_op(6'd7);
      run = 1'b1;
      tick();
      chk("t1b_pre_x", x, 6);
      chk("t1b_pre_count", count, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("t1b_x", x, 0);
      chk("t1b_count", count, 0);
      chk("t1b_drop", drop, 0);
      chk("t1b_empty", empty, 1);
      run = 1'b0;
      tick();
      reset = 1'b0;
      tick();

      // Push into a full FIFO on the first pop edge is accepted
      push_op(6'd10);
      push_op(6'd11);
      push_op(6'd12);
      push_op(6'd13);
      chk("t4_full", full, 1);
      din  = 6'd20;
      push = 1'b1;
      tick();
      push = 1'b0;
      tick();
      run = 1'b1;
      tick();
      chk("t4_x0", x, 10);
      chk("t4_count", count, 4);
      chk("t4_drop", drop, 0);
      tick(); chk("t4_x1", x, 11);
      tick(); chk("t4_x2", x, 12);
      tick(); chk("t4_x3", x, 13);
      tick(); chk("t4_x4", x, 20);
      tick(); chk("t4_x5", x, 0);
      chk("t4_empty", empty, 1);
      run = 1'b0;

      // Held button and short glitch each give one entry
      din  = 6'd7;
      push = 1'b1;
      repeat (20) tick();
      push = 1'b0;
      tick();
      tick();
      chk("t5_held", count, 1);
      din  = 6'd8;
      push = 1'b1;
      tick();
      tick();
      push = 1'b0;
      repeat (3) tick();
      chk("t5_glitch", count, 2);
      run = 1'b1;
      tick(); chk("t5_x0", x, 7);
      tick(); chk("t5_x1", x, 8);
      tick(); chk("t5_x2", x, 0);

      // Alternating push/pop with run high wraps the pointers
      max_count = 0;
      for (int i = 1; i <= 10; i++) begin
         push_op(6'(i));
         if (count > max_count) max_count = count;
         chk("t6_lat_x", x, 0);
         chk("t6_count1", count, 1);
         tick();
         chk("t6_x", x, i);
         chk("t6_count0", count, 0);
      end
      chk("t6_max_count", max_count, 1);
      chk("t6_drop", drop, 0);
      run = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
